aes_enc_ctrl: RTL and testbench
===============================

# aes_enc_ctrl

AES-128 encryption sequencer sitting between the key schedule, an external single-round datapath and the block-level stream interface. It loads a new cipher key by pulsing the key schedule's reset, accepts one plaintext block at a time, and issues rounds 0..10 to the round datapath. Each round is issued only once the matching round key is ready. It holds the running state between rounds and returns the ciphertext over a valid/ready handshake.

## Interface
- `NR`, default 10: number of AES rounds after round 0; fixed for AES-128.
- `BW`, default 128: block and key width.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `key_load`, in, 1: request to load `key_in`; accepted only when `key_ready`=1.
- `key_in`, in, 128: new cipher key.
- `key_ready`, out, 1: high in IDLE; a new key may be loaded.
- `key_valid`, out, 1: a loaded key exists; encryption permitted.
- `ks_key`, out, 128: registered key driven to the key schedule's `key` input.
- `ks_rst`, out, 1: active-low reset to the key schedule.
- `ks_w_all`, in, 1408: expanded key words from the key schedule.
- `ks_ready_idx`, in, 4: number of round keys ready, round 0 included.
- `in_valid`, in, 1: plaintext presented.
- `in_ready`, out, 1: plaintext accepted when `in_valid` and `in_ready` are both high.
- `in_block`, in, 128: plaintext.
- `rd_start`, out, 1: one-cycle pulse launching a round.
- `rd_round`, out, 4: round number 0..10. Round 0 is AddRoundKey only; round 10 omits MixColumns.
- `rd_key`, out, 128: round key for `rd_round`.
- `rd_state`, out, 128: current state into the round datapath.
- `rd_done`, in, 1: the round datapath has finished and `rd_result` is valid.
- `rd_result`, in, 128: state after the round.
- `out_valid`, out, 1: ciphertext valid.
- `out_ready`, in, 1: downstream accepts.
- `out_block`, out, 128: ciphertext.
- `busy`, out, 1: state is not IDLE.

## Operation
- **States:** IDLE, KRST, CHECK, RUN, OUT.
- **IDLE:**
  - If `key_load`: latch `key_in` into `ks_key`, drive `ks_rst`=0, load the reset counter with 1, clear `key_valid`, go to KRST.
  - Otherwise, if `in_valid` and `in_ready`: `rd_state`←`in_block`, `rnd`←0, go to CHECK.
  - `key_load` has priority over `in_valid`; `in_ready` = IDLE & `key_valid` & !`key_load`.
- **KRST:**
  - `ks_rst` stays 0 for exactly 2 cycles in total, then ←1.
  - Set `key_valid`, return to IDLE.
  - `ks_key` stays stable until the next `key_load`.
- **CHECK:**
  - When `ks_ready_idx` > `rnd`: `rd_key`←`ks_w_all[1407-128*rnd -: 128]`, `rd_round`←`rnd`, `rd_start`←1, go to RUN.
  - Otherwise stay in CHECK (key stall, unbounded).
- **RUN:**
  - `rd_start` is high only in the first RUN cycle.
  - `rd_done` is sampled in every RUN cycle, including the first.
  - On `rd_done`: `rd_state`←`rd_result`. If `rnd`==`NR`, `out_block`←`rd_result` and go to OUT; otherwise `rnd`←`rnd`+1 and go to CHECK.
- **OUT:**
  - `out_valid`=1; `out_block` is held stable.
  - On `out_ready`, go to IDLE.
- **Ignored inputs:**
  - `rd_done` outside RUN.
  - `key_load` outside IDLE.
  - `in_valid` outside IDLE.
- **Round counter:** `rnd` is 4 bits, range 0..10, never wraps.
- **Reset (including mid-operation):**
  - State IDLE; `ks_rst`=0, which holds the key schedule in reset until the first key load.
  - All other outputs 0; `key_valid`=0.
  - After any reset a key must be reloaded.

## Timing
- All outputs are registered except `in_ready`, `key_ready` and `busy`, which decode state and are combinational from state/flags.
- **Key load:** `key_load` accepted at edge 0; `ks_rst` is low in cycles 1–2 and high from cycle 3; `key_ready`=1 and `key_valid`=1 in cycle 3.
- **Encryption latency:** 23 cycles from the plaintext acceptance edge to `out_valid`=1. This assumes a zero-wait round datapath and all round keys ready:
  - CHECK/RUN take 2 cycles per round, ×11 rounds.
  - The OUT entry edge adds 1.
- Each stall cycle in CHECK or RUN adds 1 cycle to the latency.
- **Throughput:** next `in_ready` is asserted the cycle after the `out_valid`/`out_ready` handshake.

## Structure
- **Package `aes_pkg`:**
  - `AES_NR`=10, `AES_BW`=128, `W_ALL_W`=1408.
  - State-encoding localparams.
  - Function `rk_slice(w_all, rnd)`.
- **Sub-module `aes_rk_mux`:** combinational 11:1 selection of 128-bit slices from `ks_w_all` by `rnd`. The controller registers its output into `rd_key`.

## Test plan
1. **Reset:** assert `rst`=0 mid-RUN → next cycle state IDLE, `ks_rst`=0, `key_valid`=0, `out_valid`=0, `rd_start`=0, `in_ready`=0.
2. **Key load:** `key_load` with `key_in`=000102030405060708090a0b0c0d0e0f → `ks_rst` low exactly 2 cycles, `ks_key` equals `key_in`, `key_valid`=1 in cycle 3.
3. **FIPS-197 C.1 vector:** real key schedule plus behavioural round model. Plaintext 00112233445566778899aabbccddeeff → `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a. `rd_round` runs 0..10 in order, with exactly 11 `rd_start` pulses.
4. **Key stall:**
   - Stubbed `ks_ready_idx` held at 3 → controller issues rounds 0–2, then sits in CHECK with `rd_start`=0.
   - Raise `ks_ready_idx` to 11 → rounds resume, and `rd_key` for round 3 equals `ks_w_all[1023:896]`.
5. **Round wait and backpressure:**
   - `rd_done` delayed 4 cycles per round → latency 23+44.
   - `out_ready` low for 5 cycles → `out_valid` and `out_block` stay stable, and a concurrent `in_valid` is not accepted.
6. **Simultaneous requests:** `key_load` and `in_valid` asserted together in IDLE → key load taken, `in_ready`=0; the plaintext is accepted in the first IDLE cycle after KRST.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and round-key slicing for the AES-128 encryption sequencer.
package aes_pkg;

    localparam int unsigned AES_NR  = 10;
    localparam int unsigned AES_BW  = 128;
    localparam int unsigned W_ALL_W = (AES_NR + 1) * AES_BW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KRST,
        ST_CHECK,
        ST_RUN,
        ST_OUT
    } state_t;

    // Round 0 key sits in the most significant slice of the expanded key.
    function automatic logic [AES_BW-1:0] rk_slice(input logic [W_ALL_W-1:0] w_all,
                                                   input logic [3:0]         rnd);
        logic [AES_BW-1:0] k;
        k = '0;
        for (int unsigned i = 0; i <= AES_NR; i++) begin
            if (rnd == 4'(i)) k = w_all[W_ALL_W-1-AES_BW*i -: AES_BW];
        end
        return k;
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Bundle of key-schedule, round-datapath and block-stream signals around the sequencer.
interface aes_enc_ctrl_if;
    import aes_pkg::*;

    logic                 key_load;
    logic [AES_BW-1:0]    key_in;
    logic                 key_ready;
    logic                 key_valid;
    logic [AES_BW-1:0]    ks_key;
    logic                 ks_rst;
    logic [W_ALL_W-1:0]   ks_w_all;
    logic [3:0]           ks_ready_idx;
    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BW-1:0]    in_block;
    logic                 rd_start;
    logic [3:0]           rd_round;
    logic [AES_BW-1:0]    rd_key;
    logic [AES_BW-1:0]    rd_state;
    logic                 rd_done;
    logic [AES_BW-1:0]    rd_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BW-1:0]    out_block;
    logic                 busy;

    modport slave (
        input  key_load, key_in, ks_w_all, ks_ready_idx, in_valid, in_block,
               rd_done, rd_result, out_ready,
        output key_ready, key_valid, ks_key, ks_rst, in_ready, rd_start, rd_round,
               rd_key, rd_state, out_valid, out_block, busy
    );

    modport master (
        output key_load, key_in, ks_w_all, ks_ready_idx, in_valid, in_block,
               rd_done, rd_result, out_ready,
        input  key_ready, key_valid, ks_key, ks_rst, in_ready, rd_start, rd_round,
               rd_key, rd_state, out_valid, out_block, busy
    );

endinterface

// File: rtl/aes_rk_mux.sv
// Combinational 11:1 round-key selector over the expanded key words.
module aes_rk_mux
    import aes_pkg::*;
(
    input  logic [W_ALL_W-1:0] w_all,
    input  logic [3:0]         rnd,
    output logic [AES_BW-1:0]  rk
);

    always_comb rk = rk_slice(w_all, rnd);

endmodule

// File: rtl/aes_enc_ctrl.sv
// AES-128 encryption sequencer: key-schedule reset, per-round issue gated on key
// availability, running state between rounds and ciphertext handshake.
module aes_enc_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned BW = AES_BW
)(
    input  logic          clk,
    input  logic          rst,
    aes_enc_ctrl_if.slave bus
);

    state_t          state_q, state_d;
    logic [3:0]      rnd_q;
    logic            krst_cnt_q;
    logic            key_valid_q;
    logic            ks_rst_q;
    logic [BW-1:0]   ks_key_q;
    logic            rd_start_q;
    logic [3:0]      rd_round_q;
    logic [BW-1:0]   rd_key_q;
    logic [BW-1:0]   rd_state_q;
    logic            out_valid_q;
    logic [BW-1:0]   out_block_q;
    logic [AES_BW-1:0] rk_sel;
    logic            in_ready;
    logic            key_avail;
    logic            last_rnd;

    aes_rk_mux u_rk_mux (
        .w_all (bus.ks_w_all),
        .rnd   (rnd_q),
        .rk    (rk_sel)
    );

    assign in_ready  = (state_q == ST_IDLE) && key_valid_q && !bus.key_load;
    assign key_avail = bus.ks_ready_idx > rnd_q;
    assign last_rnd  = (rnd_q == 4'(NR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.key_load)                  state_d = ST_KRST;
                else if (bus.in_valid && in_ready) state_d = ST_CHECK;
            end
            ST_KRST:  if (!krst_cnt_q)   state_d = ST_IDLE;
            ST_CHECK: if (key_avail)     state_d = ST_RUN;
            ST_RUN:   if (bus.rd_done)   state_d = last_rnd ? ST_OUT : ST_CHECK;
            ST_OUT:   if (bus.out_ready) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // ks_rst is held low from reset so the key schedule idles until the first load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_q       <= '0;
            krst_cnt_q  <= 1'b0;
            key_valid_q <= 1'b0;
            ks_rst_q    <= 1'b0;
            ks_key_q    <= '0;
            rd_start_q  <= 1'b0;
            rd_round_q  <= '0;
            rd_key_q    <= '0;
            rd_state_q  <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
        end else begin
            rd_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.key_load) begin
                        ks_key_q    <= bus.key_in;
                        ks_rst_q    <= 1'b0;
                        krst_cnt_q  <= 1'b1;
                        key_valid_q <= 1'b0;
                    end else if (bus.in_valid && in_ready) begin
                        rd_state_q <= bus.in_block;
                        rnd_q      <= '0;
                    end
                end
                ST_KRST: begin
                    if (krst_cnt_q) begin
                        krst_cnt_q <= 1'b0;
                    end else begin
                        ks_rst_q    <= 1'b1;
                        key_valid_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (key_avail) begin
                        rd_key_q   <= rk_sel;
                        rd_round_q <= rnd_q;
                        rd_start_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.rd_done) begin
                        rd_state_q <= bus.rd_result;
                        if (last_rnd) begin
                            out_block_q <= bus.rd_result;
                            out_valid_q <= 1'b1;
                        end else begin
                            rnd_q <= rnd_q + 4'd1;
                        end
                    end
                end
                ST_OUT: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.key_valid = key_valid_q;
    assign bus.ks_key    = ks_key_q;
    assign bus.ks_rst    = ks_rst_q;
    assign bus.in_ready  = in_ready;
    assign bus.rd_start  = rd_start_q;
    assign bus.rd_round  = rd_round_q;
    assign bus.rd_key    = rd_key_q;
    assign bus.rd_state  = rd_state_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl with a behavioural AES-128 key schedule and round model.
module tb_aes_enc_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_enc_ctrl_if m ();

    aes_enc_ctrl #(.NR(10), .BW(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]    sbox [256];
    int            rd_delay = 0;
    int            pend = -1;
    bit            ks_stub = 1'b0;
    logic [3:0]    stub_idx = 4'd0;
    logic [1407:0] stub_w = '0;
    logic [127:0]  cur_key = '0;
    logic [3:0]    rnd_log [$];
    logic [127:0]  key_log [$];

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- AES reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            inv = '0;
            for (int j = 1; j < 256; j++) if (gm(x, 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [3:0] r);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        if (r == 4'd0) return s ^ k;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr + 4*((c+rr) % 4)];
        if (r != 4'd10) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [1407:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [1407:0] wa);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r <= 10; r++) s = aes_round(s, wa[1407-128*r -: 128], 4'(r));
        return s;
    endfunction

    // ---------------- environment: key schedule and round datapath ----------------
    initial begin
        m.ks_ready_idx = '0;
        m.ks_w_all     = '0;
        forever begin
            @(posedge clk); #1;
            if (m.ks_rst !== 1'b1) m.ks_ready_idx = '0;
            else if (ks_stub) begin
                m.ks_w_all     = stub_w;
                m.ks_ready_idx = stub_idx;
            end else begin
                m.ks_w_all     = expand_key(m.ks_key);
                m.ks_ready_idx = 4'd11;
            end
        end
    end

    initial begin
        m.rd_done   = 1'b0;
        m.rd_result = '0;
        forever begin
            @(posedge clk); #1;
            m.rd_done = 1'b0;
            if (m.rd_start === 1'b1) begin
                rnd_log.push_back(m.rd_round);
                key_log.push_back(m.rd_key);
                pend = rd_delay;
            end
            if (pend == 0) begin
                m.rd_result = aes_round(m.rd_state, m.rd_key, m.rd_round);
                m.rd_done   = 1'b1;
                pend        = -1;
            end else if (pend > 0) pend--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_key(input logic [127:0] key);
        m.key_load = 1'b1;
        m.key_in   = key;
        tick();
        m.key_load = 1'b0;
        repeat (2) tick();
        cur_key = key;
    endtask

    task automatic run_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
        int n;
        m.in_block = pt;
        m.in_valid = 1'b1;
        #1;
        n = 0;
        while (m.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        m.in_valid = 1'b0;
        lat = 1;
        while (m.out_valid !== 1'b1 && lat < 2000) begin tick(); lat++; end
        if (m.out_valid !== 1'b1) lat = -1;
        ct = m.out_block;
    endtask

    task automatic finish_block();
        m.out_ready = 1'b1;
        tick();
        m.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) tick();
        n_tests++; if (m.ks_rst !== 1'b0) begin n_fail++; $display("FAIL rst_ks_rst: got %b want 0", m.ks_rst); end
        n_tests++; if (m.ks_key !== '0) begin n_fail++; $display("FAIL rst_ks_key: got %h want 0", m.ks_key); end
        rst = 1'b1;
        tick();
        n_tests++; if (m.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", m.busy); end
        n_tests++; if (m.key_ready !== 1'b1) begin n_fail++; $display("FAIL rst_key_ready: got %b want 1", m.key_ready); end
        n_tests++; if (m.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_key_valid: got %b want 0", m.key_valid); end
        n_tests++; if (m.out_valid !== 1'b0 || m.rd_start !== 1'b0) begin n_fail++; $display("FAIL rst_outs: out_valid=%b rd_start=%b want 0 0", m.out_valid, m.rd_start); end
        n_tests++; if (m.out_block !== '0 || m.rd_state !== '0) begin n_fail++; $display("FAIL rst_data: out_block=%h rd_state=%h want 0", m.out_block, m.rd_state); end
        m.in_valid = 1'b1;
        m.in_block = 128'hdeadbeef;
        #1;
        n_tests++; if (m.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", m.in_ready); end
        repeat (3) tick();
        n_tests++; if (m.busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: busy=%b want 0", m.busy); end
        m.in_valid = 1'b0;
    endtask

    task automatic test_key_load();
        logic [5:1] ksr;
        logic [3:1] kv;
        m.key_load = 1'b1;
        m.key_in   = FIPS_KEY;
        #1;
        n_tests++; if (m.key_ready !== 1'b1) begin n_fail++; $display("FAIL kl_ready_idle: got %b want 1", m.key_ready); end
        tick();
        m.key_load = 1'b0;
        m.key_in   = {$urandom, $urandom, $urandom, $urandom};
        n_tests++; if (m.key_ready !== 1'b0 || m.busy !== 1'b1) begin n_fail++; $display("FAIL kl_krst: key_ready=%b busy=%b want 0 1", m.key_ready, m.busy); end
        for (int c = 1; c <= 5; c++) begin
            ksr[c] = m.ks_rst;
            if (c <= 3) kv[c] = m.key_valid;
            if (c == 3) begin
                n_tests++; if (m.key_ready !== 1'b1) begin n_fail++; $display("FAIL kl_ready_c3: got %b want 1", m.key_ready); end
            end
            if (c < 5) tick();
        end
        n_tests++; if (ksr !== 5'b11100) begin n_fail++; $display("FAIL kl_ks_rst_profile: got %b want 11100 (cycles 5..1)", ksr); end
        n_tests++; if (kv !== 3'b100) begin n_fail++; $display("FAIL kl_key_valid_profile: got %b want 100 (cycles 3..1)", kv); end
        n_tests++; if (m.ks_key !== FIPS_KEY) begin n_fail++; $display("FAIL kl_ks_key: got %h want %h", m.ks_key, FIPS_KEY); end
        cur_key = FIPS_KEY;
    endtask

    task automatic test_fips();
        logic [127:0] ct;
        int lat;
        bit ok;
        rd_delay = 0;
        rnd_log.delete();
        key_log.delete();
        run_block(FIPS_PT, ct, lat);
        n_tests++; if (ct !== FIPS_CT) begin n_fail++; $display("FAIL fips_ct: got %h want %h", ct, FIPS_CT); end
        n_tests++; if (lat != 23) begin n_fail++; $display("FAIL fips_latency: got %0d want 23", lat); end
        n_tests++; if (rnd_log.size() != 11) begin n_fail++; $display("FAIL fips_pulses: got %0d want 11", rnd_log.size()); end
        ok = (rnd_log.size() == 11);
        for (int i = 0; i < rnd_log.size() && i < 11; i++) if (rnd_log[i] != 4'(i)) ok = 0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fips_round_order: got %p want 0..10", rnd_log); end
        n_tests++; if (key_log.size() < 11 || key_log[10] !== expand_key(FIPS_KEY)[127:0]) begin
            n_fail++; $display("FAIL fips_rk10: got %h want %h", (key_log.size() < 11) ? 128'h0 : key_log[10], expand_key(FIPS_KEY)[127:0]); end
        finish_block();
        n_tests++; if (m.in_ready !== 1'b1 || m.busy !== 1'b0) begin n_fail++; $display("FAIL fips_throughput: in_ready=%b busy=%b want 1 0", m.in_ready, m.busy); end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, ct, exp_ct;
        int lat;
        rd_delay = 4;
        pt = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = aes_encrypt(pt, expand_key(cur_key));
        run_block(pt, ct, lat);
        n_tests++; if (lat != 23 + 44) begin n_fail++; $display("FAIL bp_latency: got %0d want 67", lat); end
        n_tests++; if (ct !== exp_ct) begin n_fail++; $display("FAIL bp_ct: got %h want %h", ct, exp_ct); end
        m.in_valid = 1'b1;
        m.in_block = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++; if (m.out_valid !== 1'b1 || m.out_block !== exp_ct) begin
                n_fail++; $display("FAIL bp_hold_c%0d: out_valid=%b out_block=%h want 1 %h", c, m.out_valid, m.out_block, exp_ct); end
            n_tests++; if (m.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, m.in_ready); end
            tick();
        end
        m.in_valid = 1'b0;
        finish_block();
        n_tests++; if (m.busy !== 1'b0 || m.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: busy=%b out_valid=%b want 0 0", m.busy, m.out_valid); end
        rd_delay = 0;
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct, exp_ct;
        logic [1407:0] wa;
        int lat, d;
        for (int k = 0; k < 3; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            load_key(key);
            wa = expand_key(key);
            for (int b = 0; b < 3; b++) begin
                pt = {$urandom, $urandom, $urandom, $urandom};
                d = $urandom_range(0, 3);
                rd_delay = d;
                exp_ct = aes_encrypt(pt, wa);
                run_block(pt, ct, lat);
                n_tests++; if (ct !== exp_ct) begin n_fail++; $display("FAIL rand_ct k%0d b%0d: got %h want %h", k, b, ct, exp_ct); end
                n_tests++; if (lat != 23 + 11*d) begin n_fail++; $display("FAIL rand_latency k%0d b%0d: got %0d want %0d", k, b, lat, 23 + 11*d); end
                finish_block();
            end
        end
        rd_delay = 0;
    endtask

    task automatic test_key_stall();
        logic [127:0] pt, exp_ct;
        int n;
        bit ok;
        ks_stub = 1'b1;
        stub_idx = 4'd3;
        for (int i = 0; i < 44; i++) stub_w[32*i +: 32] = $urandom;
        load_key({$urandom, $urandom, $urandom, $urandom});
        rd_delay = 0;
        rnd_log.delete();
        key_log.delete();
        pt = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = aes_encrypt(pt, stub_w);
        m.in_block = pt;
        m.in_valid = 1'b1;
        tick();
        m.in_valid = 1'b0;
        repeat (30) tick();
        ok = (rnd_log.size() == 3);
        for (int i = 0; i < rnd_log.size() && i < 3; i++) if (rnd_log[i] != 4'(i)) ok = 0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_rounds: got %p want 0,1,2", rnd_log); end
        n_tests++; if (m.rd_start !== 1'b0 || m.busy !== 1'b1 || m.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: rd_start=%b busy=%b out_valid=%b want 0 1 0", m.rd_start, m.busy, m.out_valid); end
        stub_idx = 4'd11;
        n = 0;
        while (m.out_valid !== 1'b1 && n < 200) begin tick(); n++; end
        n_tests++; if (m.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume: out_valid=%b want 1 within 200 cycles", m.out_valid); end
        n_tests++; if (key_log.size() < 4 || key_log[3] !== stub_w[1023:896]) begin
            n_fail++; $display("FAIL stall_rk3: got %h want %h", (key_log.size() < 4) ? 128'h0 : key_log[3], stub_w[1023:896]); end
        n_tests++; if (m.out_block !== exp_ct) begin n_fail++; $display("FAIL stall_ct: got %h want %h", m.out_block, exp_ct); end
        finish_block();
        ks_stub = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [127:0] key, pt, exp_ct;
        int lat;
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = aes_encrypt(pt, expand_key(key));
        m.key_load = 1'b1;
        m.key_in   = key;
        m.in_valid = 1'b1;
        m.in_block = pt;
        #1;
        n_tests++; if (m.in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_c0_in_ready: got %b want 0", m.in_ready); end
        tick();
        m.key_load = 1'b0;
        #1;
        n_tests++; if (m.in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_c1_in_ready: got %b want 0", m.in_ready); end
        tick();
        n_tests++; if (m.in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_c2_in_ready: got %b want 0", m.in_ready); end
        tick();
        n_tests++; if (m.in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_c3_in_ready: got %b want 1", m.in_ready); end
        tick();
        m.in_valid = 1'b0;
        cur_key = key;
        n_tests++; if (m.busy !== 1'b1) begin n_fail++; $display("FAIL simul_accept: busy=%b want 1", m.busy); end
        lat = 1;
        while (m.out_valid !== 1'b1 && lat < 2000) begin tick(); lat++; end
        n_tests++; if (lat != 23) begin n_fail++; $display("FAIL simul_latency: got %0d want 23", lat); end
        n_tests++; if (m.out_block !== exp_ct) begin n_fail++; $display("FAIL simul_ct: got %h want %h", m.out_block, exp_ct); end
        finish_block();
    endtask

    task automatic test_reset_midrun();
        logic [127:0] pt, ct, exp_ct;
        int lat;
        rd_delay = 2;
        m.in_block = {$urandom, $urandom, $urandom, $urandom};
        m.in_valid = 1'b1;
        tick();
        m.in_valid = 1'b0;
        repeat (10) tick();
        n_tests++; if (m.busy !== 1'b1) begin n_fail++; $display("FAIL mid_running: busy=%b want 1", m.busy); end
        rst = 1'b0;
        #1;
        pend = -1;
        n_tests++; if (m.busy !== 1'b0 || m.ks_rst !== 1'b0 || m.key_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_state: busy=%b ks_rst=%b key_valid=%b want 0 0 0", m.busy, m.ks_rst, m.key_valid); end
        n_tests++; if (m.out_valid !== 1'b0 || m.rd_start !== 1'b0 || m.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_outs: out_valid=%b rd_start=%b in_ready=%b want 0 0 0", m.out_valid, m.rd_start, m.in_ready); end
        tick();
        rst = 1'b1;
        m.in_valid = 1'b1;
        repeat (3) tick();
        n_tests++; if (m.busy !== 1'b0 || m.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_needs_key: busy=%b in_ready=%b want 0 0", m.busy, m.in_ready); end
        m.in_valid = 1'b0;
        rd_delay = 0;
        load_key({$urandom, $urandom, $urandom, $urandom});
        pt = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = aes_encrypt(pt, expand_key(cur_key));
        run_block(pt, ct, lat);
        n_tests++; if (ct !== exp_ct || lat != 23) begin
            n_fail++; $display("FAIL mid_recover: ct=%h lat=%0d want %h 23", ct, lat, exp_ct); end
        finish_block();
    endtask

    initial begin
        m.key_load  = 1'b0;
        m.key_in    = '0;
        m.in_valid  = 1'b0;
        m.in_block  = '0;
        m.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_key_load();
        test_fips();
        test_backpressure();
        test_random();
        test_key_stall();
        test_simultaneous();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
